util_axis_capture: RTL and testbench

UTIL_AXIS_CAPTURE -- requirements
Module: util_axis_capture

---
 rtl/util_axis_capture_pkg.sv | 13 +
 rtl/util_sdpram.sv | 36 +++
 rtl/util_axis_capture.sv | 121 ++++++++++++
 tb/tb_util_axis_capture.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_axis_capture_pkg.sv
// Shared types and default sizes for the AXI-Stream capture buffer.
package util_axis_capture_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/util_sdpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Only the read register is reset; the array itself keeps its contents.
module util_sdpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the array gives the pre-write word on an address collision.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/util_axis_capture.sv
// Captures up to 2^ADDR_WIDTH AXI-Stream words into a buffer after an arm pulse.
// Define UTIL_AXIS_CAPTURE_CHECKSUM_EN to add a running sum output (checksum).
module util_axis_capture
  import util_axis_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  capture_done
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH:0] LAST_INDEX = {1'b0, {ADDR_WIDTH{1'b1}}};

  cap_state_e          state_reg, state_next;
  logic [ADDR_WIDTH:0] count_reg, count_next;
  logic                tready_reg;
  logic                done_reg;
  logic                start;
  logic                transfer;
  logic                wr_en;

  assign start    = arm & ~abort & (state_reg != CAPTURE);
  assign transfer = s_axis_data_tvalid & tready_reg;
  // The top count bit means the buffer is full; never wrap the write address.
  assign wr_en    = transfer & ~count_reg[ADDR_WIDTH];

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = CAPTURE;
          count_next = '0;
        end
      end
      CAPTURE: begin
        if (wr_en) begin
          count_next = count_reg + 1'b1;
          if (count_reg == LAST_INDEX) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Handshake and done flags are decoded from the next state so they are pure registers.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      tready_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      tready_reg <= (state_next == CAPTURE);
      done_reg   <= (state_next == DONE);
    end
  end

  assign s_axis_data_tready = tready_reg;
  assign capture_done       = done_reg;
  assign word_count         = count_reg;

`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_reg, sum_next;

  always_comb begin
    sum_next = sum_reg;
    if (start) begin
      sum_next = '0;
    end else if (wr_en) begin
      sum_next = sum_reg + s_axis_data_tdata;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end

  assign checksum = sum_reg;
`endif

  util_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buffer (
    .aclk    (aclk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (count_reg[ADDR_WIDTH-1:0]),
    .wr_data (s_axis_data_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_util_axis_capture.sv
// Randomized bench for util_axis_capture against a behavioural capture model.
// Checksum comparisons are active when UTIL_AXIS_CAPTURE_CHECKSUM_EN is defined.
module tb_util_axis_capture;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          aclk;
  logic          rst_n;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          arm;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   word_count;
  logic          capture_done;
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  util_axis_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk               (aclk),
    .rst_n              (rst_n),
    .s_axis_data_tvalid (tvalid),
    .s_axis_data_tready (tready),
    .s_axis_data_tdata  (tdata),
    .arm                (arm),
    .abort              (abort),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .word_count         (word_count),
    .capture_done       (capture_done)
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
    ,
    .checksum           (checksum)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what has been captured, whether a capture is running or full.
  bit [DW-1:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_active;
  bit          m_full;
  int          m_count;
  bit [DW-1:0] m_sum;
  bit [DW-1:0] m_rd;
  bit          m_rd_known;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_full     = 1'b0;
    m_count    = 0;
    m_sum      = '0;
    m_rd       = '0;
    m_rd_known = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit was_active;
    was_active = m_active;
    m_rd_known = m_known[rd_addr];
    m_rd       = m_mem[rd_addr];
    if (tvalid && m_active && m_count < DEPTH) begin
      m_mem[m_count]   = tdata;
      m_known[m_count] = 1'b1;
      m_count++;
      m_sum = m_sum + tdata;
      if (m_count == DEPTH) begin
        m_active = 1'b0;
        m_full   = 1'b1;
      end
    end
    if (abort) begin
      m_active = 1'b0;
      m_full   = 1'b0;
    end else if (arm && !was_active) begin
      m_active = 1'b1;
      m_full   = 1'b0;
      m_count  = 0;
      m_sum    = '0;
    end
  endtask

  task automatic compare_all();
    check("tready", tready, m_active);
    check("done", capture_done, m_full);
    check("count", word_count, m_count);
    if (m_rd_known) check("rd_data", rd_data, m_rd);
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge aclk);
    #1;
    compare_all();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, tready, 1'b0);
    check({tag, "_done"}, capture_done, 1'b0);
    check({tag, "_count"}, word_count, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    int edges;
    rst_n   = 1'b1;
    tvalid  = 1'b0;
    tdata   = '0;
    arm     = 1'b0;
    abort   = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("por");
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    rst_n = 1'b1;
    cycle();
    $display("txn reset checks=%0d", checks);

    // Full capture with data = index, then refused writes while full
    pulse_arm();
    tvalid = 1'b1;
    for (int c = 0; c < DEPTH + 50 && !capture_done; c++) begin
      tdata = m_count;
      cycle();
    end
    check("s1_done", capture_done, 1'b1);
    check("s1_tready", tready, 1'b0);
    check("s1_count", word_count, DEPTH);
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
    check("s1_checksum", checksum, 32'h0007FE00);
`endif
    for (int c = 0; c < 5; c++) begin
      tdata = 32'hDEAD0000 + c;
      cycle();
    end
    check("s1_full_hold", word_count, DEPTH);
    tvalid  = 1'b0;
    rd_addr = 5;
    cycle();
    check("s1_rd5", rd_data, 5);
    $display("txn full_capture words=%0d", word_count);

    // Throttled capture: tvalid alternates, first beat valid
    pulse_arm();
`ifdef UTIL_AXIS_CAPTURE_CHECKSUM_EN
    check("s2_checksum_clr", checksum, 0);
`endif
    edges  = 1;
    tvalid = 1'b1;
    while (!capture_done && edges < 2200) begin
      tdata = m_count;
      cycle();
      edges++;
      tvalid = ~tvalid;
    end
    tvalid = 1'b0;
    check("s2_cycles", edges, 2048);
    check("s2_done", capture_done, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      cycle();
      check("s2_rd", rd_data, i);
    end
    $display("txn throttled_capture cycles=%0d", edges);

    // Abort after 100 transfers, readback, re-arm
    pulse_arm();
    tvalid = 1'b1;
    while (m_count < 100) begin
      tdata = $urandom;
      cycle();
    end
    tvalid = 1'b0;
    abort  = 1'b1;
    cycle();
    abort  = 1'b0;
    check("s3_count", word_count, 100);
    check("s3_tready", tready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      rd_addr = AW'(i);
      cycle();
    end
    pulse_arm();
    check("s3_rearm_count", word_count, 0);
    check("s3_rearm_tready", tready, 1'b1);
    $display("txn abort_rearm count=%0d", word_count);

    // Arm and abort together from IDLE
    abort = 1'b1;
    cycle();
    arm = 1'b1;
    cycle();
    arm   = 1'b0;
    abort = 1'b0;
    check("s4_tready", tready, 1'b0);
    cycle();
    check("s4_tready_hold", tready, 1'b0);
    $display("txn arm_abort_collision tready=%0b", tready);

    // Asynchronous reset in the middle of a capture
    pulse_arm();
    for (int c = 0; c < 2000 && m_count < 300; c++) begin
      tvalid  = 1'($urandom);
      tdata   = $urandom;
      rd_addr = AW'($urandom);
      cycle();
    end
    tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_async");
    model_reset();
    @(posedge aclk);
    #1;
    check_reset_outputs("s5_held");
    @(negedge aclk);
    rst_n = 1'b1;
    cycle();
    cycle();
    pulse_arm();
    for (int c = 0; c < 4000 && !capture_done; c++) begin
      tvalid  = 1'($urandom);
      tdata   = $urandom;
      rd_addr = AW'($urandom);
      cycle();
    end
    tvalid = 1'b0;
    check("s5_done", capture_done, 1'b1);
    check("s5_count", word_count, DEPTH);
    for (int c = 0; c < 64; c++) begin
      rd_addr = AW'($urandom);
      cycle();
    end
    $display("txn reset_mid_capture words=%0d", word_count);

    // Random traffic with sporadic arm/abort
    for (int c = 0; c < 3000; c++) begin
      tvalid  = 1'($urandom);
      tdata   = $urandom;
      rd_addr = AW'($urandom);
      arm     = ($urandom_range(0, 49) == 0);
      abort   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    arm    = 1'b0;
    abort  = 1'b0;
    tvalid = 1'b0;
    cycle();
    $display("txn random_traffic count=%0d", word_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
